// File: rtl/seq_dispatch.sv
// seq_dispatch: fetches op codes from the memory block, pulses one device select per op,
// waits for all devices ready, then streams an ADC word or a timestamp. Optional WAIT timeout: TIMEOUT_EN.
module seq_dispatch #(
  parameter int NUM_DEV  = 4,
  parameter int OP_W     = 4,
  parameter int DATA_W   = 16,
  parameter int ADC_W    = 14,
  parameter int ADC_DEV  = 1,
  parameter int TIME_W   = 48,
  parameter int CS_PULSE = 1,
  parameter int TMO_CYC  = 1023
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_en,
  output logic               o_rdy,
  output logic               o_mblock_en,
  output logic               o_mblock_clr,
  input  logic               i_mblock_valid,
  input  logic [OP_W-1:0]    i_dev_no,
  output logic [NUM_DEV-1:0] o_dev_cs,
  input  logic [NUM_DEV-1:0] i_dev_rdy,
  input  logic [ADC_W-1:0]   i_adc_out,
  input  logic [TIME_W-1:0]  i_time_out,
  output logic               o_data_out_en,
  output logic [DATA_W-1:0]  o_data_out,
  output logic               o_cd_en,
  input  logic               i_cd_rdy,
  output logic               o_clock_en,
  output logic               o_err
);
  localparam int NW  = (TIME_W + DATA_W - 1) / DATA_W;
  localparam int PCW = $clog2(CS_PULSE + 1);
  localparam int WCW = $clog2(NW + 1);
  localparam logic [OP_W-1:0] OP_TIME = OP_W'(NUM_DEV + 1);
  localparam logic [OP_W-1:0] OP_ADC  = OP_W'(ADC_DEV);
  localparam logic [OP_W-1:0] OP_MAXD = OP_W'(NUM_DEV);

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_LOAD, S_CALL, S_WAIT, S_OUT, S_DONE} state_t;
  state_t r_state, w_nxt;

  logic                  r_ld_ph;
  logic [OP_W-1:0]       r_op;
  logic [TIME_W-1:0]     r_ts;
  logic [PCW-1:0]        r_pcnt;
  logic [WCW-1:0]        r_wcnt;
  logic                  r_rdy, r_mben, r_clr, r_cd_en, r_err, r_dout_en;
  logic [NUM_DEV-1:0]    r_cs;
  logic [DATA_W-1:0]     r_dout;

  logic                  w_rdy_n, w_mben_n, w_clr_n, w_cd_en_n, w_err_n, w_dout_en_n;
  logic [NUM_DEV-1:0]    w_cs_n;
  logic [DATA_W-1:0]     w_dout_n;
  logic                  w_all_rdy, w_ld_go, w_op_dev, w_op_bad, w_out_last, w_tmo;
  logic [OP_W-1:0]       w_op_sel;
  logic [TIME_W-1:0]     w_src;
  logic [WCW-1:0]        w_widx;
  logic [NW*DATA_W-1:0]  w_tpad;
  logic [DATA_W-1:0]     w_tword, w_apad;

  assign w_all_rdy  = &i_dev_rdy;
  // dev_no is valid on the second LOAD cycle, one cycle after the read strobe
  assign w_ld_go    = (r_state == S_LOAD) && r_ld_ph;
  assign w_op_dev   = (i_dev_no != '0) && (i_dev_no <= OP_MAXD);
  assign w_op_bad   = (i_dev_no > OP_TIME);
  assign w_out_last = (r_op == OP_ADC) || (r_wcnt == WCW'(NW - 1));
  assign w_op_sel   = (r_state == S_LOAD) ? i_dev_no : r_op;

`ifdef TIMEOUT_EN
  localparam int TCW = $clog2(TMO_CYC + 1);
  logic [TCW-1:0] r_tcnt;
  assign w_tmo = (r_tcnt == TCW'(TMO_CYC - 1));
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) r_tcnt <= '0;
    else       r_tcnt <= (r_state == S_WAIT) ? r_tcnt + 1'b1 : '0;
`else
  assign w_tmo = (TMO_CYC < 0);
`endif

  // First time word comes straight from time_out while the snapshot is being taken
  always_comb begin
    w_src   = (r_state == S_LOAD) ? i_time_out : r_ts;
    w_widx  = (r_state == S_LOAD) ? '0 : r_wcnt + 1'b1;
    w_tpad  = '0;
    w_tpad[TIME_W-1:0] = w_src;
    w_tword = '0;
    for (int i = 0; i < NW; i++)
      if (w_widx == WCW'(i)) w_tword = w_tpad[i*DATA_W +: DATA_W];
    w_apad  = '0;
    w_apad[ADC_W-1:0] = i_adc_out;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state   <= S_IDLE;
      r_ld_ph   <= 1'b0;
      r_op      <= '0;
      r_ts      <= '0;
      r_pcnt    <= '0;
      r_wcnt    <= '0;
      r_rdy     <= 1'b0;
      r_mben    <= 1'b0;
      r_clr     <= 1'b1;
      r_cd_en   <= 1'b0;
      r_err     <= 1'b0;
      r_dout_en <= 1'b0;
      r_cs      <= '0;
      r_dout    <= '0;
    end else begin
      r_state   <= w_nxt;
      r_ld_ph   <= (r_state == S_LOAD) && !r_ld_ph;
      if (w_ld_go) r_op <= i_dev_no;
      if (w_ld_go && (i_dev_no == OP_TIME)) r_ts <= i_time_out;
      r_pcnt    <= (r_state == S_CALL) ? r_pcnt + 1'b1 : '0;
      r_wcnt    <= (r_state == S_OUT) ? r_wcnt + 1'b1 : '0;
      r_rdy     <= w_rdy_n;
      r_mben    <= w_mben_n;
      r_clr     <= w_clr_n;
      r_cd_en   <= w_cd_en_n;
      r_err     <= w_err_n;
      r_dout_en <= w_dout_en_n;
      r_cs      <= w_cs_n;
      r_dout    <= w_dout_n;
    end
  end

  always_comb begin
    w_nxt = r_state;
    case (r_state)
      S_IDLE:  if (i_en) w_nxt = S_FETCH;
      S_FETCH: w_nxt = i_mblock_valid ? S_LOAD : S_DONE;
      S_LOAD:
        if (r_ld_ph) begin
          if (w_op_dev)                  w_nxt = S_CALL;
          else if (i_dev_no == OP_TIME)  w_nxt = S_OUT;
          else                           w_nxt = S_FETCH;
        end
      S_CALL:  if (r_pcnt == PCW'(CS_PULSE - 1)) w_nxt = S_WAIT;
      S_WAIT:
        if (w_all_rdy) w_nxt = (r_op == OP_ADC) ? S_OUT : S_FETCH;
        else if (w_tmo) w_nxt = S_FETCH;
      S_OUT:   if (w_out_last) w_nxt = S_FETCH;
      S_DONE:  if (i_cd_rdy) w_nxt = S_IDLE;
      default: w_nxt = S_IDLE;
    endcase
    if (!i_en) w_nxt = S_IDLE;
  end

  for (genvar g = 0; g < NUM_DEV; g++) begin : g_cs
    assign w_cs_n[g] = (w_nxt == S_CALL) && (w_op_sel == OP_W'(g + 1));
  end

  always_comb begin
    w_mben_n    = (r_state == S_FETCH) && i_en && i_mblock_valid;
    w_clr_n     = (w_nxt == S_IDLE);
    w_cd_en_n   = i_en && ((r_state == S_IDLE) || r_cd_en);
    w_dout_en_n = (w_nxt == S_OUT);

    w_rdy_n = r_rdy;
    if ((r_state == S_FETCH) && i_en && !i_mblock_valid)           w_rdy_n = 1'b1;
    else if ((r_state == S_IDLE) && i_en)                          w_rdy_n = 1'b0;
    else if (!i_en && (r_state != S_IDLE) && (r_state != S_DONE))  w_rdy_n = 1'b0;

    w_err_n = r_err;
    if ((r_state == S_IDLE) && i_en)                                w_err_n = 1'b0;
    else if (i_en && w_ld_go && w_op_bad)                           w_err_n = 1'b1;
    else if (i_en && (r_state == S_WAIT) && !w_all_rdy && w_tmo)    w_err_n = 1'b1;

    w_dout_n = r_dout;
    if (w_nxt == S_OUT) w_dout_n = (r_state == S_WAIT) ? w_apad : w_tword;
  end

  assign o_rdy         = r_rdy;
  assign o_mblock_en   = r_mben;
  assign o_mblock_clr  = r_clr;
  assign o_dev_cs      = r_cs;
  assign o_data_out_en = r_dout_en;
  assign o_data_out    = r_dout;
  assign o_cd_en       = r_cd_en;
  assign o_clock_en    = r_cd_en;
  assign o_err         = r_err;
endmodule

// File: tb/tb_seq_dispatch.sv
// Scoreboard bench for seq_dispatch: stimulus pushes expected cs pulses / data words, a negedge monitor pops them.
module tb_seq_dispatch;
  localparam int NUM_DEV = 4, OP_W = 4, DATA_W = 16, ADC_W = 14, TIME_W = 48;

  logic clk = 1'b0, rst = 1'b1, en = 1'b0, cd_rdy = 1'b0;
  logic rdy, mblock_en, mblock_clr, mblock_valid, data_out_en, cd_en, clock_en, err;
  logic [OP_W-1:0]    dev_no;
  logic [NUM_DEV-1:0] dev_cs;
  logic [NUM_DEV-1:0] dev_rdy = '1;
  logic [ADC_W-1:0]   adc_out = '0;
  logic [TIME_W-1:0]  time_out, ts_base = '0, ts_adv = '0;
  logic [DATA_W-1:0]  data_out;

  always #5 clk = ~clk;

  seq_dispatch #(.NUM_DEV(NUM_DEV), .OP_W(OP_W), .DATA_W(DATA_W), .ADC_W(ADC_W), .ADC_DEV(1),
                 .TIME_W(TIME_W), .CS_PULSE(1), .TMO_CYC(16)) dut (
    .i_clk(clk), .i_rst(rst), .i_en(en), .o_rdy(rdy), .o_mblock_en(mblock_en),
    .o_mblock_clr(mblock_clr), .i_mblock_valid(mblock_valid), .i_dev_no(dev_no),
    .o_dev_cs(dev_cs), .i_dev_rdy(dev_rdy), .i_adc_out(adc_out), .i_time_out(time_out),
    .o_data_out_en(data_out_en), .o_data_out(data_out), .o_cd_en(cd_en), .i_cd_rdy(cd_rdy),
    .o_clock_en(clock_en), .o_err(err));

  // memory block and device models
  logic [OP_W-1:0] prog [16];
  int  plen = 0, ptr = 0, rcnt = 0, rdy_dly = 5, cyc = 0;
  bit  rdy_hold = 1'b0;
  assign mblock_valid = (ptr < plen);
  assign time_out     = ts_base + ts_adv;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mblock_clr) ptr <= 0;
    else if (mblock_en) begin dev_no <= prog[ptr[3:0]]; ptr <= ptr + 1; end
    if (|dev_cs) begin dev_rdy <= '0; rcnt <= rdy_dly; end
    else if (!rdy_hold && rcnt != 0) begin
      rcnt <= rcnt - 1;
      if (rcnt == 1) dev_rdy <= '1;
    end
    if (data_out_en) ts_adv <= ts_adv + 48'h1111_1111_1111;
  end

  typedef struct packed { logic [DATA_W-1:0] d; logic consec; } dexp_t;
  dexp_t              exp_d [$];
  logic [NUM_DEV-1:0] exp_cs [$];
  int n_vec = 0, n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h required 0x%0h", nm, act, expv);
    end
  endtask

  task automatic push_d(input logic [DATA_W-1:0] d, input logic c);
    dexp_t e;
    e.d = d; e.consec = c;
    exp_d.push_back(e);
  endtask

  // monitor
  int last_dcyc = -10;
  logic [NUM_DEV-1:0] prev_cs = '0;
  always @(negedge clk) if (!rst) begin
    dexp_t e;
    logic [NUM_DEV-1:0] ec;
    if (data_out_en) begin
      if (exp_d.size() == 0) begin
        n_vec++; n_fail++;
        $display("FAIL unexpected_data: got 0x%0h required no word", data_out);
      end else begin
        e = exp_d.pop_front();
        chk("data_out", data_out, e.d);
        if (e.consec) chk("data_consecutive", cyc - last_dcyc, 1);
      end
      last_dcyc = cyc;
    end
    if (dev_cs != '0) begin
      chk("cs_pulse_width", prev_cs, 0);
      if (exp_cs.size() == 0) begin
        n_vec++; n_fail++;
        $display("FAIL unexpected_cs: got 0x%0h required none", dev_cs);
      end else begin
        ec = exp_cs.pop_front();
        chk("dev_cs", dev_cs, ec);
      end
    end
    prev_cs = dev_cs;
  end

  task automatic wait_rdy(input logic v, input int budget, input string nm);
    int k = 0;
    while (rdy !== v && k < budget) begin @(negedge clk); k++; end
    chk(nm, rdy, v);
  endtask

  task automatic drained(input string nm);
    chk({nm, "_data_left"}, exp_d.size(), 0);
    chk({nm, "_cs_left"}, exp_cs.size(), 0);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) prog[i] = '0;
    #23;
    chk("rst_mblock_clr", mblock_clr, 1);
    chk("rst_rdy", rdy, 0);
    chk("rst_mblock_en", mblock_en, 0);
    chk("rst_dev_cs", dev_cs, 0);
    chk("rst_data_out_en", data_out_en, 0);
    chk("rst_data_out", data_out, 0);
    chk("rst_cd_en", cd_en, 0);
    chk("rst_clock_en", clock_en, 0);
    chk("rst_err", err, 0);
    @(negedge clk); rst = 1'b0;

    // single ADC op
    prog[0] = 4'd1; plen = 1; adc_out = 14'h1ABC; rdy_dly = 5;
    exp_cs.push_back(4'b0001); push_d(16'h1ABC, 1'b0);
    en = 1'b1;
    @(negedge clk); @(negedge clk);
    chk("run_cd_en", cd_en, 1);
    chk("run_clock_en", clock_en, 1);
    chk("run_mblock_clr", mblock_clr, 0);
    wait_rdy(1'b1, 100, "adc_rdy");
    chk("adc_err", err, 0);
    drained("adc");
    en = 1'b0;
    @(negedge clk);
    chk("done_off_clr", mblock_clr, 1);
    chk("done_off_rdy", rdy, 1);
    chk("done_off_cd_en", cd_en, 0);

    // timestamp op, snapshot must survive time_out advancing
    prog[0] = 4'd5; plen = 1; ts_base = 48'h0003_0002_0001 - ts_adv;
    push_d(16'h0001, 1'b0); push_d(16'h0002, 1'b1); push_d(16'h0003, 1'b1);
    en = 1'b1;
    wait_rdy(1'b0, 10, "time_rdy_clear");
    wait_rdy(1'b1, 100, "time_rdy");
    chk("time_err", err, 0);
    drained("time");
    en = 1'b0; @(negedge clk);

    // NOP, device 3, illegal op 9
    prog[0] = 4'd0; prog[1] = 4'd3; prog[2] = 4'd9; plen = 3; rdy_dly = 3;
    exp_cs.push_back(4'b0100);
    en = 1'b1;
    wait_rdy(1'b0, 10, "mix_rdy_clear");
    wait_rdy(1'b1, 100, "mix_rdy");
    chk("mix_err", err, 1);
    drained("mix");
    en = 1'b0; @(negedge clk);
    chk("err_held_idle", err, 1);

    // abort in WAIT for op 2, then replay
    prog[0] = 4'd2; prog[1] = 4'd1; plen = 2; rdy_hold = 1'b1; rdy_dly = 5;
    exp_cs.push_back(4'b0010);
    en = 1'b1;
    begin
      int k = 0;
      while (dev_cs !== 4'b0010 && k < 50) begin @(negedge clk); k++; end
    end
    chk("abort_cs_seen", dev_cs, 4'b0010);
    @(negedge clk); @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    chk("abort_clr", mblock_clr, 1);
    chk("abort_cd_en", cd_en, 0);
    chk("abort_clock_en", clock_en, 0);
    chk("abort_rdy", rdy, 0);
    chk("abort_cs", dev_cs, 0);
    chk("abort_dout_en", data_out_en, 0);
    chk("abort_mben", mblock_en, 0);
    rdy_hold = 1'b0;
    exp_cs.push_back(4'b0010); exp_cs.push_back(4'b0001); push_d(16'h1ABC, 1'b0);
    en = 1'b1;
    wait_rdy(1'b1, 200, "replay_rdy");
    drained("replay");

    // repeat from DONE on cd_rdy
    exp_cs.push_back(4'b0010); exp_cs.push_back(4'b0001); push_d(16'h1ABC, 1'b0);
    @(negedge clk); cd_rdy = 1'b1;
    @(negedge clk); cd_rdy = 1'b0;
    chk("repeat_idle_clr", mblock_clr, 1);
    chk("repeat_idle_rdy", rdy, 1);
    chk("repeat_cd_en", cd_en, 1);
    wait_rdy(1'b0, 10, "repeat_rdy_clear");
    wait_rdy(1'b1, 200, "repeat_rdy");
    drained("repeat");

`ifdef TIMEOUT_EN
    en = 1'b0; @(negedge clk);
    prog[0] = 4'd3; prog[1] = 4'd4; plen = 2; rdy_hold = 1'b1;
    exp_cs.push_back(4'b0100); exp_cs.push_back(4'b1000);
    en = 1'b1;
    begin
      int k = 0;
      while (err !== 1'b1 && k < 100) begin @(negedge clk); k++; end
    end
    chk("tmo_err", err, 1);
    rdy_hold = 1'b0;
    wait_rdy(1'b1, 200, "tmo_rdy");
    drained("tmo");
`endif

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
